// File: rtl/seq_shift_add_multiplier_if.sv
// Handshake/bus bundle for the sequential shift-and-add multiplier.
// The master side issues operands and a start request. The slave side returns
// the status flags and the product register.
interface seq_shift_add_multiplier_if #(
   parameter int WIDTH = 32
);
   logic                 start;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   product;

   modport master (output start, a, b, input busy, done, product);
   modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/seq_shift_add_multiplier.sv
// Multi-cycle unsigned WIDTHxWIDTH -> 2*WIDTH shift-and-add multiplier.
// It reuses the existing 2*WIDTH ripple-carry adder datapath.
// Each RUN cycle does the following:
//   - it adds the shifted multiplicand into the partial product when the current
//     multiplier LSB is set;
//   - it shifts the multiplicand left and the multiplier right.
// Latency is fixed at WIDTH RUN cycles, followed by one DONE cycle.
// WIDTH must be 32 so that the product matches the 64-bit adder.

// One bit slice of the ripple-carry adder.
module rca_cell (
   input  logic x,
   input  logic y,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = x ^ y ^ cin;
   assign cout = (x & y) | (cin & (x ^ y));
endmodule

// W-bit ripple-carry adder built as a chain of bit slices.
module rca_adder #(
   parameter int W = 64
) (
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout
);
   logic [W:0] c;

   assign c[0] = cin;

   // Slice i consumes carry c[i] and produces carry c[i+1].
   rca_cell u_cell [W-1:0] (
      .x    (x),
      .y    (y),
      .cin  (c[W-1:0]),
      .s    (sum),
      .cout (c[W:1])
   );

   assign cout = c[W];
endmodule

module seq_shift_add_multiplier #(
   parameter int WIDTH = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   seq_shift_add_multiplier_if.slave   mul
);
   localparam int PW = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH) + 1;

   localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [PW-1:0]    mcand;
   logic [WIDTH-1:0] mplier;
   logic [PW-1:0]    acc;
   logic [CW-1:0]    cnt;
   logic [PW-1:0]    product_q;

   logic [PW-1:0]    sum;
   logic [PW-1:0]    acc_next;

   // For in-range operands the partial product never exceeds 2*WIDTH bits.
   // The carry-out is therefore structurally present but never consumed.
   logic             add_cout_unused;

   rca_adder #(.W(PW)) u_add (
      .x    (acc),
      .y    (mcand),
      .cin  (1'b0),
      .sum  (sum),
      .cout (add_cout_unused)
   );

   // The partial product takes the adder result only when the current multiplier bit is set.
   always_comb begin
      acc_next = acc;
      if (mplier[0]) acc_next = sum;
   end

   // Control FSM and datapath registers. Reset overrides every other input.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         mcand     <= '0;
         mplier    <= '0;
         acc       <= '0;
         cnt       <= '0;
         product_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (mul.start) begin
                  mcand     <= {{(PW-WIDTH){1'b0}}, mul.a};
                  mplier    <= mul.b;
                  acc       <= '0;
                  cnt       <= '0;
                  product_q <= '0;
                  state     <= RUN;
               end
            end
            RUN: begin
               acc    <= acc_next;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + 1'b1;
               // The final iteration publishes the result, including the last conditional add.
               if (cnt == LAST_ITER) begin
                  product_q <= acc_next;
                  state     <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign mul.busy    = (state == RUN);
   assign mul.done    = (state == DONE);
   assign mul.product = product_q;
endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Directed plus randomized bench for seq_shift_add_multiplier.
// Expected products come from plain 64-bit multiplication.
// Expected latencies come from the fixed timing rules: done follows the
// accepting edge by 33 cycles, and back-to-back multiplies are spaced 34 cycles apart.
module tb_seq_shift_add_multiplier;
   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   seq_shift_add_multiplier_if #(.WIDTH(32)) mif ();

   seq_shift_add_multiplier #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .mul (mif)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
      logic [63:0] xx;
      logic [63:0] yy;
      xx = {32'b0, x};
      yy = {32'b0, y};
      return xx * yy;
   endfunction

   // The adder carry-out must stay low while the multiplier is running.
   always @(negedge clk) begin
      if (mif.busy === 1'b1) begin
         checks++;
         assert (dut.add_cout_unused === 1'b0) else begin
            failures++;
            $error("FAIL adder_cout observed=%b expected=0", dut.add_cout_unused);
         end
      end
   end

   // Hard stop in case something upstream never returns.
   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // This task issues one multiply and checks its done latency and product.
   // With repulse set, it also re-asserts start (with a=1, b=1) at k+10 while
   // the multiply is busy. That start must be ignored, so the product stays x*y
   // and exactly one done pulse is produced.
   task automatic do_mul(input logic [31:0] x, input logic [31:0] y,
                         input string tag, input bit repulse);
      logic [63:0] exp;
      int cyc;
      int nbusy;
      int extra;
      bit got;
      exp = ref_mul(x, y);
      @(negedge clk);
      mif.start = 1'b1; mif.a = x; mif.b = y;
      @(posedge clk);
      #1;
      mif.start = 1'b0; mif.a = $urandom; mif.b = $urandom;
      cyc = 0; nbusy = 0; got = 1'b0;
      while (!got && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (repulse && cyc == 10) begin
            mif.start = 1'b1; mif.a = 32'd1; mif.b = 32'd1;
         end
         if (repulse && cyc == 11) mif.start = 1'b0;
         if (mif.done === 1'b1) got = 1'b1;
         else if (mif.busy === 1'b1) nbusy++;
      end
      chk({tag, "_done_seen"}, 64'(got), 64'd1);
      chk({tag, "_latency"}, 64'(cyc), 64'd33);
      chk({tag, "_busy_cycles"}, 64'(nbusy), 64'd32);
      chk({tag, "_product"}, mif.product, exp);
      @(negedge clk);
      chk({tag, "_done_one_cycle"}, 64'(mif.done), 64'd0);
      chk({tag, "_product_held"}, mif.product, exp);
      if (repulse) begin
         extra = 0;
         repeat (40) begin
            @(negedge clk);
            if (mif.done === 1'b1) extra++;
         end
         chk({tag, "_extra_done"}, 64'(extra), 64'd0);
      end
   endtask

   initial begin
      int cyc;
      int extra;
      bit got;
      logic [31:0] cur_a;
      logic [31:0] cur_b;

      // Reset state.
      rst = 1'b1; mif.start = 1'b0; mif.a = '0; mif.b = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 64'(mif.busy), 64'd0);
      chk("rst_done", 64'(mif.done), 64'd0);
      chk("rst_product", mif.product, 64'd0);

      // Reset takes priority over start while idle.
      mif.start = 1'b1; mif.a = 32'd9; mif.b = 32'd9;
      @(negedge clk);
      chk("rst_over_start_busy", 64'(mif.busy), 64'd0);
      mif.start = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      chk("idle_hold_busy", 64'(mif.busy), 64'd0);

      do_mul(32'd3, 32'd5, "3x5", 1'b0);
      do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, "max_x_max", 1'b0);
      chk("max_literal", mif.product, 64'hFFFF_FFFE_0000_0001);
      do_mul(32'd0, 32'h1234_5678, "zero_a", 1'b0);
      do_mul(32'h1234_5678, 32'd0, "zero_b", 1'b0);
      do_mul(32'd7, 32'd9, "repulse", 1'b1);
      chk("repulse_literal", mif.product, 64'h3F);
      do_mul($urandom, $urandom, "rand0", 1'b0);
      do_mul($urandom, $urandom, "rand1", 1'b0);

      // Abort a multiply with reset part-way through RUN.
      @(negedge clk);
      mif.start = 1'b1; mif.a = 32'hDEAD_BEEF; mif.b = 32'h1000;
      @(posedge clk);
      #1;
      mif.start = 1'b0;
      repeat (15) @(negedge clk);
      chk("abort_busy_before", 64'(mif.busy), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_busy", 64'(mif.busy), 64'd0);
      chk("abort_done", 64'(mif.done), 64'd0);
      chk("abort_product", mif.product, 64'd0);
      rst = 1'b0;
      extra = 0;
      repeat (40) begin
         @(negedge clk);
         if (mif.done === 1'b1) extra++;
      end
      chk("abort_no_done", 64'(extra), 64'd0);
      do_mul(32'd2, 32'd2, "after_abort", 1'b0);

      // Hold start high and present a fresh random operand pair for each accept.
      @(negedge clk);
      cur_a = $urandom; cur_b = $urandom;
      mif.a = cur_a; mif.b = cur_b; mif.start = 1'b1;
      for (int n = 0; n < 200; n++) begin
         cyc = 0; got = 1'b0;
         while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (mif.done === 1'b1) got = 1'b1;
         end
         chk("held_done_seen", 64'(got), 64'd1);
         chk("held_product", mif.product, ref_mul(cur_a, cur_b));
         if (n > 0) chk("held_spacing", 64'(cyc), 64'd34);
         cur_a = $urandom; cur_b = $urandom;
         mif.a = cur_a; mif.b = cur_b;
      end
      mif.start = 1'b0;
      repeat (40) @(negedge clk);
      chk("final_idle_busy", 64'(mif.busy), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/seq_shift_add_multiplier.md
Name: seq_shift_add_multiplier

Overview:
- Multi-cycle unsigned 32x32 -> 64-bit shift-and-add multiplier.
- Sits directly upstream of, and around, the 64-bit ripple-carry adder. Each cycle it feeds the adder the running partial product and the shifted multiplicand, then registers the adder's sum.
- Gives the ALU a multiply path that reuses the existing adder datapath instead of adding a combinational array multiplier.

Parameters:
- WIDTH, 32, operand width. Must be 32 because the product width 2*WIDTH matches the 64-bit adder; any other value is unsupported.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a multiply; sampled only in IDLE.
- a  input  32  multiplicand, sampled on the accepting edge.
- b  input  32  multiplier, sampled on the accepting edge.
- busy  output  1  high while a multiply is in progress (RUN state).
- done  output  1  one-cycle pulse when product becomes valid.
- product  output  64  result register; holds its value until the next accepted start.

Behaviour:
- Reset, sampled on a clk edge with rst=1:
  - state=IDLE; busy=0, done=0, product=0.
  - Internal multiplicand, multiplier, accumulator and counter are cleared.
  - rst has priority over all other inputs in every state.
- Internal registers:
  - mcand[63:0]: multiplicand, zero-extended.
  - mplier[31:0]: multiplier.
  - acc[63:0]: partial product.
  - cnt[5:0]: iteration counter.
- Adder hookup:
  - One 64-bit ripple-carry adder instance, operands acc and mcand, carry-in 0.
  - Carry-out is unused; it cannot be 1 for valid operands. The bench flags it as an error if it is ever 1 in RUN.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN when start=1:
    - mcand <= {32'b0, a}; mplier <= b; acc <= 0; cnt <= 0; product <= 0.
    - busy goes high on the next cycle.
  - IDLE with start=0: hold all registers.
  - RUN, every cycle:
    - If mplier[0]=1, acc <= adder sum; otherwise acc holds.
    - mcand <= mcand << 1 (logical); mplier <= mplier >> 1 (logical); cnt <= cnt + 1.
  - RUN -> DONE on the edge that completes the iteration with cnt=31, i.e. after exactly 32 RUN cycles. On that edge product <= final acc value, including the last conditional add.
  - DONE: done=1 and busy=0 for exactly one cycle, then unconditionally -> IDLE.
- Output decode:
  - busy=1 only in RUN; done=1 only in DONE.
  - product is a register. It changes only on the RUN->DONE edge, on an accepted start (cleared to 0), or on reset.
- Latency and throughput:
  - start sampled at edge k puts the FSM in RUN for edges k+1..k+32.
  - done is high in the cycle after edge k+32, i.e. observable at edge k+33.
  - No early termination: latency is fixed at 32 RUN cycles regardless of operand values.
  - Maximum throughput is one multiply per 34 cycles: start accepted again in IDLE at edge k+34.
- Boundary conditions:
  - start while busy or done: ignored, no effect on the operation in flight. a and b changing during RUN have no effect.
  - start held high continuously: a new multiply is accepted each time IDLE is reached.
  - Operand 0 on either side: product 0 with the same latency.
  - Reset mid-RUN: abort. The next cycle shows IDLE, busy=0, done=0, product=0, and no done pulse for the aborted operation.

Test Plan:
- rst=1 for 2 cycles, then a=3, b=5, start pulse at edge k -> busy=1 for 32 cycles; done=1 at k+33 only; product=64'h000000000000000F, held afterwards.
- a=32'hFFFFFFFF, b=32'hFFFFFFFF -> product=64'hFFFFFFFE00000001 at k+33; adder carry-out never 1 during RUN.
- a=0, b=32'h12345678, and separately a=32'h12345678, b=0 -> product=0, done still at exactly k+33.
- Start accepted with a=7, b=9; start re-pulsed at k+10 with a=1, b=1 -> product=63 (64'h3F); the k+10 start is ignored and there is one done pulse only.
- Start with a=32'hDEADBEEF, b=32'h1000; rst=1 at k+15 -> busy=0, done=0, product=0 next cycle; no done pulse follows. A new start with a=2, b=2 then yields 4.
- start held high, 200 random operand pairs changed each accept -> each product equals a*b reference, done pulses spaced 34 cycles apart.
